// File: rtl/fifo_pkg.sv
// Shared types, constants and sizing helpers for the synchronous FIFO family.
package fifo_pkg;

   // Bit positions inside the sticky error vector.
   typedef enum logic [0:0] {
      OVERFLOW  = 1'b0,
      UNDERFLOW = 1'b1
   } err_bit_e;

   localparam int unsigned ERR_BITS      = 2;
   localparam int unsigned DEF_AE_THRESH = 2;
   localparam int unsigned DEF_AF_MARGIN = 2;

   function automatic int unsigned clog2_ceil(input int unsigned value);
      int unsigned result;
      result = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((32'd1 << i) < value) result = i + 1;
      end
      return result;
   endfunction

   // Bits needed to hold an occupancy count of 0..depth inclusive.
   function automatic int unsigned level_width(input int unsigned depth);
      return clog2_ceil(depth + 1);
   endfunction

endpackage

// File: rtl/fifo_ram.sv
// Dual-port FIFO storage: synchronous write, read port registered (FWFT=0)
// or asynchronous (FWFT=1). Shared by the sync and async FIFO controllers.
module fifo_ram #(
   parameter int unsigned WIDTH   = 8,
   parameter int unsigned POINTER = 4,
   parameter int unsigned FWFT    = 0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               clr,
   input  logic               wr_en,
   input  logic [POINTER-1:0] wr_addr,
   input  logic [WIDTH-1:0]   wr_data,
   input  logic               rd_en,
   input  logic [POINTER-1:0] rd_addr,
   output logic [WIDTH-1:0]   rd_data
);

   localparam int unsigned DEPTH = 2**POINTER;

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   if (FWFT == 0) begin : g_reg_read
      logic [WIDTH-1:0] rd_q;

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            rd_q <= '0;
         end else if (clr) begin
            rd_q <= '0;
         end else if (rd_en) begin
            rd_q <= mem[rd_addr];
         end
      end

      assign rd_data = rd_q;
   end else begin : g_async_read
      logic unused_ctrl;

      // Fall-through read has no output register to reset, clear or enable.
      assign unused_ctrl = &{1'b0, rst, clr, rd_en};
      assign rd_data     = mem[rd_addr];
   end

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO controller: pointers, occupancy counter, threshold flags
// and sticky error flags around a fifo_ram instance.
module sync_fifo_ctrl
   import fifo_pkg::*;
#(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned POINTER   = 4,
   parameter int unsigned FWFT      = 0,
   parameter int unsigned AF_THRESH = (2**POINTER) - DEF_AF_MARGIN,
   parameter int unsigned AE_THRESH = DEF_AE_THRESH
) (
   input  logic             clk,
   input  logic             areset,
   input  logic             flush,
   input  logic             wren,
   input  logic [WIDTH-1:0] data_in,
   output logic             full,
   output logic             almost_full,
   input  logic             rden,
   output logic [WIDTH-1:0] data_out,
   output logic             empty,
   output logic             almost_empty,
   output logic [POINTER:0] level,
   output logic             overflow,
   output logic             underflow
);

   localparam int unsigned DEPTH = 2**POINTER;
   localparam int unsigned LVL_W = level_width(DEPTH);

   if (AF_THRESH < 1 || AF_THRESH > DEPTH || AE_THRESH >= DEPTH) begin : g_bad_thresh
      $error("sync_fifo_ctrl: thresholds out of range (AF_THRESH=%0d AE_THRESH=%0d DEPTH=%0d)",
             AF_THRESH, AE_THRESH, DEPTH);
   end

   logic [POINTER-1:0]  wr_ptr;
   logic [POINTER-1:0]  rd_ptr;
   logic [LVL_W-1:0]    level_q;
   logic [ERR_BITS-1:0] err_q;
   logic                wr_acc;
   logic                rd_acc;

   assign full         = (level_q == LVL_W'(DEPTH));
   assign empty        = (level_q == '0);
   assign almost_full  = (level_q >= LVL_W'(AF_THRESH));
   assign almost_empty = (level_q <= LVL_W'(AE_THRESH));
   assign level        = level_q;
   assign overflow     = err_q[OVERFLOW];
   assign underflow    = err_q[UNDERFLOW];

   // A read frees a slot in the same cycle, so a full FIFO still accepts wren&rden.
   assign wr_acc = wren & (~full | rden) & ~flush;
   assign rd_acc = rden & ~empty & ~flush;

   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         level_q <= '0;
         err_q   <= '0;
      end else if (flush) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         level_q <= '0;
         err_q   <= '0;
      end else begin
         if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
         if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
         if (wr_acc && !rd_acc) begin
            level_q <= level_q + 1'b1;
         end else if (rd_acc && !wr_acc) begin
            level_q <= level_q - 1'b1;
         end
         if (wren && full && !rden) err_q[OVERFLOW]  <= 1'b1;
         if (rden && empty)         err_q[UNDERFLOW] <= 1'b1;
      end
   end

   fifo_ram #(
      .WIDTH   (WIDTH),
      .POINTER (POINTER),
      .FWFT    (FWFT)
   ) u_ram (
      .clk     (clk),
      .rst     (areset),
      .clr     (flush),
      .wr_en   (wr_acc),
      .wr_addr (wr_ptr),
      .wr_data (data_in),
      .rd_en   (rd_acc),
      .rd_addr (rd_ptr),
      .rd_data (data_out)
   );

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Directed bench for sync_fifo_ctrl: registered-read, fall-through and
// custom-threshold instances driven from a vector table plus corner sequences.
module tb_sync_fifo_ctrl;

   typedef struct {
      logic       wren;
      logic       rden;
      logic [7:0] din;
      logic [4:0] lvl;
      logic       full;
      logic       af;
      logic       empty;
      logic       ae;
      logic       ovf;
      logic       unf;
      logic [7:0] dout;
   } vec_t;

   vec_t vecs[$];

   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   logic clk = 1'b0;
   logic areset = 1'b1;

   logic       flush0 = 1'b0, wren0 = 1'b0, rden0 = 1'b0;
   logic [7:0] din0 = '0, dout0;
   logic       full0, af0, empty0, ae0, ovf0, unf0;
   logic [4:0] lvl0;

   logic       flush1 = 1'b0, wren1 = 1'b0, rden1 = 1'b0;
   logic [7:0] din1 = '0, dout1;
   logic       full1, af1, empty1, ae1, ovf1, unf1;
   logic [4:0] lvl1;

   logic       flush2 = 1'b0, wren2 = 1'b0, rden2 = 1'b0;
   logic [7:0] din2 = '0, dout2;
   logic       full2, af2, empty2, ae2, ovf2, unf2;
   logic [4:0] lvl2;

   always #5 clk = ~clk;

   sync_fifo_ctrl #(.WIDTH(8), .POINTER(4), .FWFT(0)) u0 (
      .clk(clk), .areset(areset), .flush(flush0), .wren(wren0), .data_in(din0),
      .full(full0), .almost_full(af0), .rden(rden0), .data_out(dout0),
      .empty(empty0), .almost_empty(ae0), .level(lvl0),
      .overflow(ovf0), .underflow(unf0));

   sync_fifo_ctrl #(.WIDTH(8), .POINTER(4), .FWFT(1)) u1 (
      .clk(clk), .areset(areset), .flush(flush1), .wren(wren1), .data_in(din1),
      .full(full1), .almost_full(af1), .rden(rden1), .data_out(dout1),
      .empty(empty1), .almost_empty(ae1), .level(lvl1),
      .overflow(ovf1), .underflow(unf1));

   sync_fifo_ctrl #(.WIDTH(8), .POINTER(4), .FWFT(0), .AF_THRESH(12), .AE_THRESH(4)) u2 (
      .clk(clk), .areset(areset), .flush(flush2), .wren(wren2), .data_in(din2),
      .full(full2), .almost_full(af2), .rden(rden2), .data_out(dout2),
      .empty(empty2), .almost_empty(ae2), .level(lvl2),
      .overflow(ovf2), .underflow(unf2));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic void add(input logic w, r, input logic [7:0] d, input logic [4:0] lvl,
                               input logic full, af, empty, ae, ovf, unf,
                               input logic [7:0] dout);
      vec_t v;
      v.wren = w; v.rden = r; v.din = d; v.lvl = lvl;
      v.full = full; v.af = af; v.empty = empty; v.ae = ae;
      v.ovf = ovf; v.unf = unf; v.dout = dout;
      vecs.push_back(v);
   endfunction

   // Drive one cycle on the selected instance, return 1 time unit after the edge.
   task automatic step(input int unsigned inst, input logic f, w, r, input logic [7:0] d);
      @(negedge clk);
      case (inst)
         0: begin flush0 = f; wren0 = w; rden0 = r; din0 = d; end
         1: begin flush1 = f; wren1 = w; rden1 = r; din1 = d; end
         default: begin flush2 = f; wren2 = w; rden2 = r; din2 = d; end
      endcase
      @(posedge clk);
      #1;
      flush0 = 1'b0; wren0 = 1'b0; rden0 = 1'b0;
      flush1 = 1'b0; wren1 = 1'b0; rden1 = 1'b0;
      flush2 = 1'b0; wren2 = 1'b0; rden2 = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] q[$];
      logic [7:0] exp_d;
      logic       w;

      // Table for u0: fill, overflow, drain, underflow.
      for (int i = 0; i < 16; i++)
         add(1'b1, 1'b0, 8'(i), 5'(i + 1), i == 15, (i + 1) >= 14, 1'b0, (i + 1) <= 2,
             1'b0, 1'b0, 8'h00);
      add(1'b1, 1'b0, 8'hFF, 5'd16, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
      for (int j = 0; j < 16; j++)
         add(1'b0, 1'b1, 8'h00, 5'(15 - j), 1'b0, (15 - j) >= 14, j == 15, (15 - j) <= 2,
             1'b1, 1'b0, 8'(j));
      add(1'b0, 1'b1, 8'h00, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h0F);

      // Reset released away from a clock edge.
      #23 areset = 1'b0;
      #1;
      chk("rst_level", 32'(lvl0), 0);
      chk("rst_flags{f,af,e,ae,ov,un}", {full0, af0, empty0, ae0, ovf0, unf0}, 6'b001100);
      chk("rst_dout", 32'(dout0), 0);
      chk("rst_u1_flags", {full1, af1, empty1, ae1, ovf1, unf1}, 6'b001100);
      chk("rst_u2_dout", 32'(dout2), 0);

      foreach (vecs[k]) begin
         step(0, 1'b0, vecs[k].wren, vecs[k].rden, vecs[k].din);
         chk($sformatf("vec%0d_level", k), 32'(lvl0), 32'(vecs[k].lvl));
         chk($sformatf("vec%0d_flags{f,af,e,ae,ov,un}", k),
             {full0, af0, empty0, ae0, ovf0, unf0},
             {vecs[k].full, vecs[k].af, vecs[k].empty, vecs[k].ae, vecs[k].ovf, vecs[k].unf});
         chk($sformatf("vec%0d_dout", k), 32'(dout0), 32'(vecs[k].dout));
      end

      // Asynchronous reset in the middle of traffic.
      for (int i = 0; i < 3; i++) step(0, 1'b0, 1'b1, 1'b0, 8'(8'h21 + i));
      @(negedge clk);
      #2 areset = 1'b1;
      #1;
      chk("midrst_level", 32'(lvl0), 0);
      chk("midrst_flags{f,af,e,ae,ov,un}", {full0, af0, empty0, ae0, ovf0, unf0}, 6'b001100);
      chk("midrst_dout", 32'(dout0), 0);
      @(negedge clk);
      areset = 1'b0;
      step(0, 1'b0, 1'b1, 1'b0, 8'h5A);
      step(0, 1'b0, 1'b0, 1'b1, 8'h00);
      chk("postrst_first_word", 32'(dout0), 32'h5A);

      // Simultaneous read and write while full.
      for (int i = 0; i < 16; i++) step(0, 1'b0, 1'b1, 1'b0, 8'(8'h40 + i));
      chk("fill_level", 32'(lvl0), 16);
      step(0, 1'b0, 1'b1, 1'b1, 8'h3C);
      chk("fullrw_level", 32'(lvl0), 16);
      chk("fullrw_ovf", 32'(ovf0), 0);
      chk("fullrw_dout", 32'(dout0), 32'h40);
      for (int i = 0; i < 16; i++) begin
         step(0, 1'b0, 1'b0, 1'b1, 8'h00);
         chk($sformatf("fullrw_drain%0d", i), 32'(dout0), (i == 15) ? 32'h3C : 32'(8'h41 + i));
      end
      chk("fullrw_empty", 32'(empty0), 1);

      // Simultaneous read and write while empty.
      step(0, 1'b0, 1'b1, 1'b1, 8'h77);
      chk("emptyrw_level", 32'(lvl0), 1);
      chk("emptyrw_unf", 32'(unf0), 1);
      chk("emptyrw_dout_hold", 32'(dout0), 32'h3C);
      step(0, 1'b0, 1'b0, 1'b1, 8'h00);
      chk("emptyrw_readback", 32'(dout0), 32'h77);

      // Wrap-around with a scoreboard: blocks of three writes then three reads.
      step(0, 1'b1, 1'b0, 1'b0, 8'h00);
      chk("wrap_flush_unf", 32'(unf0), 0);
      for (int c = 0; c < 84; c++) begin
         w = ((c / 3) % 2) == 0;
         step(0, 1'b0, w, !w, 8'(c * 7 + 1));
         if (w) begin
            q.push_back(8'(c * 7 + 1));
         end else begin
            exp_d = q.pop_front();
            chk($sformatf("wrap%0d_dout", c), 32'(dout0), 32'(exp_d));
         end
         chk($sformatf("wrap%0d_level", c), 32'(lvl0), q.size());
         chk($sformatf("wrap%0d_err{ov,un}", c), {ovf0, unf0}, 2'b00);
      end

      // Fall-through instance.
      step(1, 1'b0, 1'b1, 1'b0, 8'hA5);
      chk("fwft_visible", 32'(dout1), 32'hA5);
      chk("fwft_flags{f,af,e,ae,ov,un}", {full1, af1, empty1, ae1, ovf1, unf1}, 6'b000100);
      step(1, 1'b0, 1'b1, 1'b0, 8'h11);
      chk("fwft_head_held", 32'(dout1), 32'hA5);
      step(1, 1'b0, 1'b0, 1'b1, 8'h00);
      chk("fwft_next", 32'(dout1), 32'h11);
      chk("fwft_level1", 32'(lvl1), 1);
      step(1, 1'b0, 1'b0, 1'b1, 8'h00);
      chk("fwft_drained{f,af,e,ae,ov,un}", {full1, af1, empty1, ae1, ovf1, unf1}, 6'b001100);
      chk("fwft_level0", 32'(lvl1), 0);

      // Custom thresholds AF=12, AE=4, then flush at level 9 with overflow set.
      for (int i = 0; i < 16; i++) begin
         step(2, 1'b0, 1'b1, 1'b0, 8'(i));
         chk($sformatf("thr_lvl%0d{f,af,e,ae}", i + 1), {full2, af2, empty2, ae2},
             {i == 15, (i + 1) >= 12, 1'b0, (i + 1) <= 4});
      end
      step(2, 1'b0, 1'b1, 1'b0, 8'hEE);
      chk("thr_ovf", 32'(ovf2), 1);
      for (int i = 0; i < 7; i++) step(2, 1'b0, 1'b0, 1'b1, 8'h00);
      chk("thr_level9", 32'(lvl2), 9);
      chk("thr_dout6", 32'(dout2), 6);
      chk("thr_ovf_sticky", 32'(ovf2), 1);
      step(2, 1'b1, 1'b1, 1'b0, 8'h99);
      chk("flush_level", 32'(lvl2), 0);
      chk("flush_flags{f,af,e,ae,ov,un}", {full2, af2, empty2, ae2, ovf2, unf2}, 6'b001100);
      chk("flush_dout", 32'(dout2), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
